// File: rtl/pipeline_control_if.sv
// Hazard/sequencing bundle between the pipeline stages and pipeline_control.
// The master modport is the controller's view; slave is the stages' view.
interface pipeline_control_if;
  logic       decode_valid;
  logic       decode_uses_rs1;
  logic       decode_uses_rs2;
  logic       decode_csr_read;
  logic [4:0] decode_rs1_address;
  logic [4:0] decode_rs2_address;
  logic       execute_valid;
  logic       execute_load;
  logic [4:0] execute_rd_address;
  logic       execute_csr_write;
  logic       execute_branch_taken;
  logic       memory_busy;
  logic       wb_valid;
  logic       wb_exception;
  logic       wb_mret;
  logic       wb_wfi;
  logic       interrupt_pending;

  logic       stall_fetch;
  logic       stall_decode;
  logic       stall_execute;
  logic       stall_memory;
  logic       invalidate_fetch;
  logic       invalidate_decode;
  logic       invalidate_execute;
  logic       invalidate_memory;
  logic       redirect;
  logic [1:0] redirect_source;
  logic       wfi_active;

  modport master (
    input  decode_valid, decode_uses_rs1, decode_uses_rs2, decode_csr_read,
           decode_rs1_address, decode_rs2_address,
           execute_valid, execute_load, execute_rd_address, execute_csr_write,
           execute_branch_taken, memory_busy,
           wb_valid, wb_exception, wb_mret, wb_wfi, interrupt_pending,
    output stall_fetch, stall_decode, stall_execute, stall_memory,
           invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
           redirect, redirect_source, wfi_active
  );

  modport slave (
    output decode_valid, decode_uses_rs1, decode_uses_rs2, decode_csr_read,
           decode_rs1_address, decode_rs2_address,
           execute_valid, execute_load, execute_rd_address, execute_csr_write,
           execute_branch_taken, memory_busy,
           wb_valid, wb_exception, wb_mret, wb_wfi, interrupt_pending,
    input  stall_fetch, stall_decode, stall_execute, stall_memory,
           invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory,
           redirect, redirect_source, wfi_active
  );
endinterface

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, bubbles,
// redirects on branch/trap/mret, and WFI parking. Outputs are combinational.
module pipeline_control #(
  parameter int unsigned CSR_SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_control_if.master    pipe
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    WFI_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] SETTLE = 3'(CSR_SETTLE_CYCLES);

  localparam logic [1:0] SRC_BRANCH = 2'd0;
  localparam logic [1:0] SRC_TRAP   = 2'd1;
  localparam logic [1:0] SRC_MEPC   = 2'd2;

  state_e     state_q, state_d;
  logic [2:0] csr_counter_q, csr_counter_d;

  logic trap_or_mret, wfi_retire, branch_taken;
  logic rs1_match, rs2_match, load_use, csr_write_ex, csr_hazard;

  logic       stall_fetch, stall_decode, stall_execute, stall_memory;
  logic       inv_fetch, inv_decode, inv_execute, inv_memory;
  logic       redirect, wfi_active;
  logic [1:0] redirect_source;

  assign trap_or_mret = pipe.wb_valid & (pipe.wb_exception | pipe.wb_mret);
  assign wfi_retire   = pipe.wb_valid & pipe.wb_wfi & ~pipe.wb_exception;
  assign branch_taken = pipe.execute_valid & pipe.execute_branch_taken;
  assign csr_write_ex = pipe.execute_valid & pipe.execute_csr_write;

  assign rs1_match = pipe.decode_uses_rs1 & (pipe.decode_rs1_address == pipe.execute_rd_address);
  assign rs2_match = pipe.decode_uses_rs2 & (pipe.decode_rs2_address == pipe.execute_rd_address);
  assign load_use  = pipe.execute_valid & pipe.execute_load & (pipe.execute_rd_address != 5'd0)
                   & pipe.decode_valid & (rs1_match | rs2_match);
  assign csr_hazard = pipe.decode_valid & pipe.decode_csr_read
                    & ((csr_counter_q != 3'd0) | csr_write_ex);

  always_comb begin
    // NOTE: every output and next-state signal gets a default here so no path
    // through the case below leaves one unassigned (which would infer a latch).
    state_d         = state_q;
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    stall_execute   = 1'b0;
    stall_memory    = 1'b0;
    inv_fetch       = 1'b0;
    inv_decode      = 1'b0;
    inv_execute     = 1'b0;
    inv_memory      = 1'b0;
    redirect        = 1'b0;
    redirect_source = SRC_BRANCH;
    wfi_active      = 1'b0;

    case (state_q)
      RUN: begin
        if (trap_or_mret) begin
          redirect        = 1'b1;
          redirect_source = pipe.wb_exception ? SRC_TRAP : SRC_MEPC;
          inv_fetch       = 1'b1;
          inv_decode      = 1'b1;
          inv_execute     = 1'b1;
          inv_memory      = 1'b1;
          state_d         = FLUSH;
        end else if (wfi_retire) begin
          inv_fetch   = 1'b1;
          inv_decode  = 1'b1;
          inv_execute = 1'b1;
          inv_memory  = 1'b1;
          state_d     = WFI_WAIT;
        end else if (pipe.memory_busy) begin
          // Whole pipe holds; lower-priority hazards re-present next cycle.
          stall_fetch   = 1'b1;
          stall_decode  = 1'b1;
          stall_execute = 1'b1;
          stall_memory  = 1'b1;
        end else if (branch_taken) begin
          redirect   = 1'b1;
          inv_fetch  = 1'b1;
          inv_decode = 1'b1;
        end else if (load_use || csr_hazard) begin
          stall_fetch = 1'b1;
          inv_decode  = 1'b1;
        end
      end
      FLUSH: begin
        inv_decode  = 1'b1;
        inv_execute = 1'b1;
        inv_memory  = 1'b1;
        state_d     = RUN;
      end
      WFI_WAIT: begin
        stall_fetch = 1'b1;
        inv_decode  = 1'b1;
        wfi_active  = 1'b1;
        if (pipe.interrupt_pending) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    csr_counter_d = csr_counter_q;
    if (state_q == RUN && trap_or_mret) begin
      csr_counter_d = 3'd0;
    end else if (csr_write_ex && !stall_execute) begin
      csr_counter_d = SETTLE;
    end else if (!pipe.memory_busy && csr_counter_q != 3'd0) begin
      csr_counter_d = csr_counter_q - 3'd1;
    end

    if (reset) begin
      stall_fetch     = 1'b0;
      stall_decode    = 1'b0;
      stall_execute   = 1'b0;
      stall_memory    = 1'b0;
      inv_fetch       = 1'b1;
      inv_decode      = 1'b1;
      inv_execute     = 1'b1;
      inv_memory      = 1'b1;
      redirect        = 1'b0;
      redirect_source = SRC_BRANCH;
      wfi_active      = 1'b0;
      state_d         = RUN;
      csr_counter_d   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    if (reset) begin
      state_q       <= RUN;
      csr_counter_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      csr_counter_q <= csr_counter_d;
    end
  end

  assign pipe.stall_fetch        = stall_fetch;
  assign pipe.stall_decode       = stall_decode;
  assign pipe.stall_execute      = stall_execute;
  assign pipe.stall_memory       = stall_memory;
  assign pipe.invalidate_fetch   = inv_fetch;
  assign pipe.invalidate_decode  = inv_decode;
  assign pipe.invalidate_execute = inv_execute;
  assign pipe.invalidate_memory  = inv_memory;
  assign pipe.redirect           = redirect;
  assign pipe.redirect_source    = redirect_source;
  assign pipe.wfi_active         = wfi_active;

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback).
- Drives the per-stage stall and invalidate inputs.
- Resolves load-use and CSR read-after-write hazards.
- Squashes wrong-path instructions on taken branches, traps and mret.
- Parks the pipeline in a WFI state until an interrupt is pending.
- Outputs are combinational from registered state plus current inputs. FSM and counter are registered.

Parameters:
CSR_SETTLE_CYCLES, 2, cycles a decode-stage CSR read is held after a CSR write leaves execute (1..7).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
decode_valid  in  1  decode holds a valid instruction
decode_uses_rs1  in  1  decode instruction reads rs1
decode_uses_rs2  in  1  decode instruction reads rs2
decode_csr_read  in  1  decode instruction reads a CSR
decode_rs1_address  in  5  rs1 of decode instruction
decode_rs2_address  in  5  rs2 of decode instruction
execute_valid  in  1  execute holds a valid instruction
execute_load  in  1  execute instruction is a load
execute_rd_address  in  5  rd of execute instruction
execute_csr_write  in  1  execute instruction writes a CSR
execute_branch_taken  in  1  execute resolved a taken branch/jump
memory_busy  in  1  data memory access not complete this cycle
wb_valid  in  1  writeback holds a valid instruction
wb_exception  in  1  retiring instruction raised an exception
wb_mret  in  1  retiring instruction is mret
wb_wfi  in  1  retiring instruction is wfi
interrupt_pending  in  1  enabled interrupt pending
stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  hold stage output register
invalidate_fetch, invalidate_decode, invalidate_execute, invalidate_memory  out  1 each  stage emits a bubble (valid_out=0)
redirect  out  1  fetch must load a new PC this cycle
redirect_source  out  2  0=branch, 1=trap vector, 2=mepc (mret), 3=reserved
wfi_active  out  1  FSM in WFI_WAIT

Behaviour:
- FSM states: RUN, FLUSH, WFI_WAIT. Registered csr_counter is 3 bits.
- While reset=1:
  - all invalidate_* = 1, all stall_* = 0, redirect = 0, wfi_active = 0.
  - Next state = RUN, csr_counter = 0.
  - Reset mid-operation abandons any FLUSH or WFI_WAIT.
- Event priority, highest first, evaluated each cycle in RUN:
  1. Trap or mret: wb_valid & (wb_exception | wb_mret).
     - redirect = 1; redirect_source = 1 for an exception, 2 for mret. Exception wins if both are set.
     - invalidate_fetch, invalidate_decode, invalidate_execute and invalidate_memory = 1.
     - Next state = FLUSH.
  2. WFI: wb_valid & wb_wfi (no exception).
     - invalidate all four stages.
     - Next state = WFI_WAIT.
  3. memory_busy:
     - stall_fetch, stall_decode, stall_execute, stall_memory = 1.
     - invalidate_memory = 1 only if memory_busy persists into writeback timing; here it is 0. Memory holds.
     - All lower-priority events are deferred, not lost: their inputs remain stable because the stages hold.
  4. Branch taken: execute_valid & execute_branch_taken.
     - redirect = 1, redirect_source = 0.
     - invalidate_fetch = 1, invalidate_decode = 1.
  5. Load-use: execute_valid & execute_load & execute_rd_address != 0 & decode_valid, and at least one of:
     - decode_uses_rs1 & rs1 == rd
     - decode_uses_rs2 & rs2 == rd
     Response: stall_fetch = 1, invalidate_decode = 1 (bubble into execute). Lasts exactly 1 cycle per hazard.
  6. CSR hazard: decode_valid & decode_csr_read & (csr_counter != 0 | (execute_valid & execute_csr_write)).
     - stall_fetch = 1, invalidate_decode = 1.
- csr_counter:
  - Loaded with CSR_SETTLE_CYCLES when execute_valid & execute_csr_write & !stall_execute.
  - Otherwise decrements toward 0 when !memory_busy. Saturates at 0, never wraps.
  - Cleared on trap/mret.
- FLUSH:
  - Exactly 1 cycle.
  - invalidate_decode, invalidate_execute and invalidate_memory = 1; redirect = 0.
  - Returns to RUN.
- WFI_WAIT:
  - stall_fetch = 1, invalidate_decode = 1, wfi_active = 1.
  - Stays while interrupt_pending = 0.
  - On interrupt_pending = 1: next state RUN, wfi_active = 0. The interrupt is taken later as a normal trap.
  - If interrupt_pending = 1 in the same cycle wfi retires, WFI_WAIT still lasts 1 cycle.
- When stall_X and invalidate_X are both 1 for the same stage, the stage holds (stall wins).
- Controller latency: 0 cycles for combinational responses; state changes take effect the next clock edge.

Test Plan:
- Reset: hold reset for 3 cycles with random inputs -> all invalidate_* = 1, stall_* = 0, redirect = 0; first cycle after release is in RUN.
- Load-use: execute load rd=5, decode uses rs2=5 -> exactly 1 cycle of stall_fetch = 1, invalidate_decode = 1. Repeat with rd=0 -> no stall.
- Branch vs load-use in the same cycle -> redirect = 1, source 0, invalidate_fetch/decode = 1, stall_fetch = 0.
- Trap: wb_exception = 1 together with memory_busy and execute_branch_taken -> redirect source 1, all four invalidates = 1, next cycle in FLUSH, then RUN. Assert wb_exception & wb_mret together -> source 1.
- CSR: CSRRW in execute, then a CSR read in decode for 3 cycles with CSR_SETTLE_CYCLES=2 -> decode CSR read stalled while counter is 2 then 1, released when counter = 0. With memory_busy held 2 cycles mid-way, the counter freezes.
- WFI: wfi retires, interrupt_pending low for 10 cycles -> wfi_active = 1 for 10+ cycles with invalidate_decode = 1. Raise interrupt_pending -> RUN on the next edge.
